kb_scan_decoder: RTL

- Sits directly upstream of the 4-digit seven-segment multiplexer, between the PS/2 receiver and the display.
- Consumes the raw PS/2 byte stream and collapses E0 (extended) and F0 (break) prefix sequences into single key events.
- Keeps a two-deep history of key codes and drives the multiplexer's four hex digits and four decimal-point inputs directly.
- Emits a one-cycle key event strobe for game logic, and recovers from truncated prefix sequences with a timeout.

---
 rtl/kb_pkg.sv | 20 ++
 rtl/kb_timeout_cnt.sv | 36 +++
 rtl/kb_scan_decoder.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/kb_pkg.sv
// Shared types and constants for the PS/2 scan-code decoder.
package kb_pkg;

    localparam logic [7:0] KB_EXT = 8'hE0;
    localparam logic [7:0] KB_BRK = 8'hF0;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        GOT_E0   = 2'd1,
        GOT_F0   = 2'd2,
        GOT_E0F0 = 2'd3
    } kb_state_e;

    typedef struct packed {
        logic [7:0] code;
        logic       ext;
        logic       brk;
    } key_event_t;

endpackage

// File: rtl/kb_timeout_cnt.sv
// Timeout counter for partial prefix sequences: load-zero, enable, expiry flag.
module kb_timeout_cnt #(
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic load_zero,
    input  logic en,
    output logic expire_c
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign expire_c = en && (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (load_zero || expire_c) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/kb_scan_decoder.sv
// Collapses PS/2 E0/F0 prefix sequences into key events and drives a
// two-deep code history onto the seven-segment multiplexer inputs.
module kb_scan_decoder
    import kb_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       rx_done_tick,
    input  logic [7:0] rx_data,
    input  logic       clear,
    output logic       key_tick,
    output logic [7:0] key_code,
    output logic       key_ext,
    output logic       key_brk,
    output logic       err_tick,
    output logic [3:0] hex3,
    output logic [3:0] hex2,
    output logic [3:0] hex1,
    output logic [3:0] hex0,
    output logic [3:0] dp_out
);

    kb_state_e  state_q, state_d;
    key_event_t latest_q, latest_d;
    key_event_t prev_q, prev_d;
    logic       key_tick_q, key_tick_d;
    logic       err_tick_q, err_tick_d;
    logic [3:0] dp_q, dp_d;

    logic       expire_c;
    logic       emit_c;
    logic       ev_ext_c;
    logic       ev_brk_c;
    logic       is_ext_c;
    logic       is_brk_c;

    kb_timeout_cnt #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk      (clk),
        .reset_n  (reset_n),
        .load_zero(clear || rx_done_tick || (state_q == IDLE)),
        .en       (state_q != IDLE),
        .expire_c (expire_c)
    );

    assign is_ext_c = (rx_data == KB_EXT);
    assign is_brk_c = (rx_data == KB_BRK);

    // Next-state, event and history update.
    always_comb begin
        state_d    = state_q;
        latest_d   = latest_q;
        prev_d     = prev_q;
        key_tick_d = 1'b0;
        err_tick_d = 1'b0;
        dp_d       = dp_q;
        emit_c     = 1'b0;
        ev_ext_c   = 1'b0;
        ev_brk_c   = 1'b0;

        if (clear) begin
            state_d  = IDLE;
            latest_d = '0;
            prev_d   = '0;
            dp_d     = 4'b1111;
        end else if (rx_done_tick) begin
            unique case (state_q)
                IDLE: begin
                    if (is_ext_c) begin
                        state_d = GOT_E0;
                    end else if (is_brk_c) begin
                        state_d = GOT_F0;
                    end else begin
                        emit_c = 1'b1;
                    end
                end
                GOT_E0: begin
                    if (is_brk_c) begin
                        state_d = GOT_E0F0;
                    end else if (!is_ext_c) begin
                        emit_c   = 1'b1;
                        ev_ext_c = 1'b1;
                        state_d  = IDLE;
                    end
                end
                GOT_F0: begin
                    if (is_ext_c) begin
                        err_tick_d = 1'b1;
                        state_d    = GOT_E0;
                    end else if (!is_brk_c) begin
                        emit_c   = 1'b1;
                        ev_brk_c = 1'b1;
                        state_d  = IDLE;
                    end
                end
                GOT_E0F0: begin
                    if (is_ext_c) begin
                        err_tick_d = 1'b1;
                        state_d    = GOT_E0;
                    end else if (!is_brk_c) begin
                        emit_c   = 1'b1;
                        ev_ext_c = 1'b1;
                        ev_brk_c = 1'b1;
                        state_d  = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end else if (expire_c) begin
            state_d    = IDLE;
            err_tick_d = 1'b1;
        end

        if (emit_c) begin
            prev_d     = latest_q;
            latest_d   = key_event_t'{code: rx_data, ext: ev_ext_c, brk: ev_brk_c};
            key_tick_d = 1'b1;
            dp_d       = ~{latest_q.ext, latest_q.brk, ev_ext_c, ev_brk_c};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            latest_q   <= '0;
            prev_q     <= '0;
            key_tick_q <= 1'b0;
            err_tick_q <= 1'b0;
            dp_q       <= 4'b1111;
        end else begin
            state_q    <= state_d;
            latest_q   <= latest_d;
            prev_q     <= prev_d;
            key_tick_q <= key_tick_d;
            err_tick_q <= err_tick_d;
            dp_q       <= dp_d;
        end
    end

    assign key_tick = key_tick_q;
    assign err_tick = err_tick_q;
    assign key_code = latest_q.code;
    assign key_ext  = latest_q.ext;
    assign key_brk  = latest_q.brk;
    assign hex3     = prev_q.code[7:4];
    assign hex2     = prev_q.code[3:0];
    assign hex1     = latest_q.code[7:4];
    assign hex0     = latest_q.code[3:0];
    assign dp_out   = dp_q;

endmodule
